// File: rtl/data_mem_lsu_if.sv
// Load/store unit bus: pipeline request/response plus memory-side signals.
// slave = LSU side, master = pipeline/memory side.
interface data_mem_lsu_if;
    // pipeline request
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // pipeline response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    // memory side
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memread;
    logic        memwrite;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic        clk_stall;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  read_data, clk_stall,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output addr, write_data, memread, memwrite, sign_mask
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output read_data, clk_stall,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  addr, write_data, memread, memwrite, sign_mask
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Data-memory load/store unit: IDLE -> ISSUE -> WAIT -> DONE sequencer.
// Ports: clk, reset_n (async, active-low), bus (data_mem_lsu_if.slave).
module data_mem_lsu #(
    parameter int STALL_TIMEOUT = 16
) (
    input logic           clk,
    input logic           reset_n,
    data_mem_lsu_if.slave bus
);

    localparam int CW = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t        state;
    logic [CW-1:0] stall_cnt;
    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    mask_q;
    logic          rd_q;
    logic          we_q;
    logic          rv_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          accept;
    logic [3:0]    mask_d;
    logic          illegal;
    logic          misaligned;

    assign accept = bus.req_valid && (state == IDLE);

    always_comb begin
        mask_d  = 4'b0000;
        illegal = 1'b0;
        case (bus.req_funct3)
            3'b000: mask_d = bus.req_write ? 4'b0001 : 4'b1001;
            3'b001: mask_d = bus.req_write ? 4'b0011 : 4'b1011;
            3'b010: mask_d = 4'b0111;
            3'b100: begin
                mask_d  = 4'b0001;
                illegal = bus.req_write;
            end
            3'b101: begin
                mask_d  = 4'b0011;
                illegal = bus.req_write;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Only the size bits matter; illegal funct3 is already flagged above.
    always_comb begin
        misaligned = 1'b0;
        if (bus.req_funct3[1:0] == 2'b01)
            misaligned = bus.req_addr[0];
        else if (bus.req_funct3[1:0] == 2'b10)
            misaligned = (bus.req_addr[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            stall_cnt <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            rd_q      <= 1'b0;
            we_q      <= 1'b0;
            rv_q      <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (illegal || misaligned) begin
                            // rejected without touching memory
                            rv_q    <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state   <= DONE;
                        end else begin
                            addr_q  <= bus.req_addr;
                            wdata_q <= bus.req_wdata;
                            mask_q  <= mask_d;
                            wr_q    <= bus.req_write;
                            rd_q    <= ~bus.req_write;
                            we_q    <= bus.req_write;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    rd_q      <= 1'b0;
                    we_q      <= 1'b0;
                    stall_cnt <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (!bus.clk_stall) begin
                        // memory already applied sign_mask to read_data
                        rdata_q <= wr_q ? 32'h0 : bus.read_data;
                        err_q   <= 1'b0;
                        rv_q    <= 1'b1;
                        state   <= DONE;
                    end else if (stall_cnt == CW'(STALL_TIMEOUT - 1)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        rv_q    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        stall_cnt <= stall_cnt + CW'(1);
                    end
                end
                DONE: begin
                    rv_q  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = rv_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = err_q;
    assign bus.addr       = addr_q;
    assign bus.write_data = wdata_q;
    assign bus.sign_mask  = mask_q;
    assign bus.memread    = rd_q;
    assign bus.memwrite   = we_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: vector table + response scoreboard.
// Ports: none (top-level testbench).
module tb_data_mem_lsu;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    data_mem_lsu_if bus();

    data_mem_lsu #(.STALL_TIMEOUT(TO)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          nstall;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_sm;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // response monitor: every resp_valid must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus.resp_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'(bus.resp_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_error", 32'(bus.resp_error), 32'(e.err));
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run(input vec_t v);
        int   budget;
        int   acc;
        logic legal;
        budget = 0;
        legal  = (v.lat > 1);
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && budget < 30) begin
            @(negedge clk);
            budget++;
        end
        chk("ready_before_req", 32'(bus.req_ready), 32'h1);
        bus.req_valid  = 1'b1;
        bus.req_write  = v.wr;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.read_data  = v.mem;
        bus.clk_stall  = 1'b0;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;
        bus.req_addr  = ~v.addr;
        bus.req_wdata = ~v.wdata;
        sb.push_back('{v.exp_rdata, v.exp_err, acc + v.lat - 1});
        @(negedge clk);
        chk("memread_issue", 32'(bus.memread), 32'(legal && !v.wr));
        chk("memwrite_issue", 32'(bus.memwrite), 32'(legal && v.wr));
        if (legal) begin
            chk("sign_mask", 32'(bus.sign_mask), 32'(v.exp_sm));
            chk("addr_issue", bus.addr, v.addr);
            chk("write_data", bus.write_data, v.wdata);
        end
        for (int k = 2; k <= v.lat; k++) begin
            @(posedge clk);
            #1;
            bus.clk_stall = (k <= 1 + v.nstall);
            @(negedge clk);
            if (k == 2) begin
                chk("strobes_low", 32'(bus.memread | bus.memwrite), 32'h0);
                chk("addr_held", bus.addr, v.addr);
            end
        end
        #1;
        chk("resp_seen", sb.size(), 32'h0);
        sb.delete();
        bus.clk_stall = 1'b0;
        @(negedge clk);
        chk("rdata_hold", bus.resp_rdata, v.exp_rdata);
        chk("error_hold", 32'(bus.resp_error), 32'(v.exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc1;
        int acc2;
        vec_t lbu;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.read_data  = 32'h0;
        bus.clk_stall  = 1'b0;

        // wr f3 addr wdata mem nstall exp_rdata err sm lat
        vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0,
                     32'hDEADBEEF, 1'b0, 4'b0111, 3};
        vecs[1]  = '{1'b1, 3'b000, 32'h13, 32'hAB, 32'h0, 1,
                     32'h0, 1'b0, 4'b0001, 4};
        vecs[2]  = '{1'b0, 3'b001, 32'h21, 32'h0, 32'h5555, 0,
                     32'h0, 1'b1, 4'b0000, 1};
        vecs[3]  = '{1'b0, 3'b010, 32'h22, 32'h0, 32'h5555, 0,
                     32'h0, 1'b1, 4'b0000, 1};
        vecs[4]  = '{1'b0, 3'b000, 32'h3, 32'h0, 32'hFFFFFFF0, 0,
                     32'hFFFFFFF0, 1'b0, 4'b1001, 3};
        vecs[5]  = '{1'b0, 3'b101, 32'h6, 32'h0, 32'h1234, 0,
                     32'h1234, 1'b0, 4'b0011, 3};
        vecs[6]  = '{1'b1, 3'b001, 32'h8, 32'hBEEF, 32'h77, 2,
                     32'h0, 1'b0, 4'b0011, 5};
        vecs[7]  = '{1'b1, 3'b010, 32'hC, 32'hCAFEF00D, 32'h77, 0,
                     32'h0, 1'b0, 4'b0111, 3};
        vecs[8]  = '{1'b0, 3'b011, 32'h0, 32'h0, 32'h99, 0,
                     32'h0, 1'b1, 4'b0000, 1};
        vecs[9]  = '{1'b1, 3'b100, 32'h4, 32'h1, 32'h99, 0,
                     32'h0, 1'b1, 4'b0000, 1};
        vecs[10] = '{1'b1, 3'b010, 32'h30, 32'h12345678, 32'h99, 100,
                     32'h0, 1'b1, 4'b0111, TO + 2};
        vecs[11] = '{1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF8001, 0,
                     32'hFFFF8001, 1'b0, 4'b1011, 3};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", bus.addr, 32'h0);
        chk("rst_wdata", bus.write_data, 32'h0);
        chk("rst_mask", 32'(bus.sign_mask), 32'h0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_strobes", 32'({bus.memread, bus.memwrite}), 32'h0);
        chk("rst_resp", 32'({bus.resp_valid, bus.resp_error}), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'h1);

        for (int i = 0; i < 12; i++) run(vecs[i]);

        // reset pulsed during WAIT of a stalled load
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h20;
        bus.read_data  = 32'h55;
        bus.clk_stall  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_memread", 32'(bus.memread), 32'h1);
        @(posedge clk);
        #2;
        chk("abort_addr_pre", bus.addr, 32'h20);
        reset_n = 1'b0;
        #1;
        chk("abort_addr", bus.addr, 32'h0);
        chk("abort_mask", 32'(bus.sign_mask), 32'h0);
        chk("abort_strobes", 32'({bus.memread, bus.memwrite}), 32'h0);
        chk("abort_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        bus.clk_stall = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_resp", 32'(bus.resp_valid), 32'h0);
        lbu = '{1'b0, 3'b100, 32'h4, 32'h0, 32'h80, 0,
                32'h80, 1'b0, 4'b0001, 3};
        run(lbu);

        // req_valid held over two loads
        acc1 = -1;
        acc2 = -1;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h40;
        bus.read_data  = 32'h11223344;
        for (int i = 0; i < 20 && acc2 < 0; i++) begin
            if (bus.req_ready === 1'b1) begin
                sb.push_back('{32'h11223344, 1'b0, cyc + 3});
                if (acc1 < 0) acc1 = cyc;
                else acc2 = cyc;
            end
            if (acc2 >= 0) begin
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("b2b_drained", sb.size(), 32'h0);
        chk("b2b_spacing", acc2 - acc1, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
